// File: rtl/ctrl_pkg.sv
// Shared types and constants for the bus-datapath control unit.
// States, opcodes, IR field positions and instruction classes.
package ctrl_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_END  = 4'd8,
      S_HALT = 4'd9
   } state_e;

   typedef enum logic [2:0] {
      C_REG3,
      C_MULDIV,
      C_UNARY,
      C_MFHI,
      C_MFLO,
      C_NOP,
      C_HALT,
      C_ILL
   } iclass_e;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

endpackage

// File: rtl/alu_ctrl_unit_if.sv
// Control-to-datapath strobe bundle.
// master = control unit, slave = datapath.
interface alu_ctrl_unit_if #(
   parameter int NREG = 16
);
   logic [31:0]     IR;
   logic            mem_rdy;
   logic            PCout, Zlowout, ZHighout;
   logic            HIout, LOout, MDRout;
   logic            MARin, PCin, MDRin, IRin, Yin;
   logic            IncPC, Read, HIin, LOin;
   logic            ZHIin, ZLOin;
   logic [4:0]      operation;
   logic [NREG-1:0] Rout;
   logic [NREG-1:0] enableReg;

   modport master (
      input  IR, mem_rdy,
      output PCout, Zlowout, ZHighout, HIout, LOout, MDRout,
      output MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
      output HIin, LOin, ZHIin, ZLOin,
      output operation, Rout, enableReg
   );

   modport slave (
      output IR, mem_rdy,
      input  PCout, Zlowout, ZHighout, HIout, LOout, MDRout,
      input  MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
      input  HIin, LOin, ZHIin, ZLOin,
      input  operation, Rout, enableReg
   );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decoder.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [4:0] opc,
   output iclass_e    cls
);

   always_comb begin
      cls = C_ILL;
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = C_REG3;
         OP_MUL, OP_DIV:                  cls = C_MULDIV;
         OP_NEG, OP_NOT:                  cls = C_UNARY;
         OP_MFHI:                         cls = C_MFHI;
         OP_MFLO:                         cls = C_MFLO;
         OP_NOP:                          cls = C_NOP;
         OP_HALT:                         cls = C_HALT;
         default:                         cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Hardwired Moore control FSM: fetch T0-T2 then class-specific execute.
// Outputs decode only the registered state and the live IR fields.
module alu_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int NREG = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  run,
   alu_ctrl_unit_if.master       dp,
   output logic [3:0]            state,
   output logic                  halted,
   output logic                  illegal
);

   state_e     state_q, state_d;
   iclass_e    cls;
   logic [4:0] opc;
   logic [3:0] ra, rb, rc;
   logic       unused_ir;

   assign opc       = dp.IR[OPC_HI:OPC_LO];
   assign ra        = dp.IR[RA_HI:RA_LO];
   assign rb        = dp.IR[RB_HI:RB_LO];
   assign rc        = dp.IR[RC_HI:RC_LO];
   assign unused_ir = ^dp.IR[RC_LO-1:0];

   function automatic logic [NREG-1:0] oh(input logic [3:0] f);
      oh    = '0;
      oh[f] = 1'b1;
   endfunction

   ctrl_decode u_dec (
      .opc (opc),
      .cls (cls)
   );

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (dp.mem_rdy) state_d = S_T2;
         S_T2:   state_d = (cls == C_HALT) ? S_HALT :
                           (cls == C_NOP)  ? S_END  : S_T3;
         S_T3:   state_d = (cls inside {C_REG3, C_MULDIV, C_UNARY}) ?
                           S_T4 : S_END;
         S_T4:   state_d = (cls inside {C_REG3, C_MULDIV}) ?
                           S_T5 : S_END;
         S_T5:   state_d = (cls == C_MULDIV) ? S_T6 : S_END;
         S_T6:   state_d = S_END;
         S_END:  state_d = run ? S_T0 : S_IDLE;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (!clr) state_d = S_IDLE;
   end

   always_comb begin
      dp.PCout     = 1'b0;
      dp.Zlowout   = 1'b0;
      dp.ZHighout  = 1'b0;
      dp.HIout     = 1'b0;
      dp.LOout     = 1'b0;
      dp.MDRout    = 1'b0;
      dp.MARin     = 1'b0;
      dp.PCin      = 1'b0;
      dp.MDRin     = 1'b0;
      dp.IRin      = 1'b0;
      dp.Yin       = 1'b0;
      dp.IncPC     = 1'b0;
      dp.Read      = 1'b0;
      dp.HIin      = 1'b0;
      dp.LOin      = 1'b0;
      dp.ZHIin     = 1'b0;
      dp.ZLOin     = 1'b0;
      dp.Rout      = '0;
      dp.enableReg = '0;
      illegal      = 1'b0;
      unique case (state_q)
         S_T0: begin
            dp.PCout = 1'b1;
            dp.MARin = 1'b1;
            dp.IncPC = 1'b1;
            dp.ZLOin = 1'b1;
         end
         S_T1: begin
            dp.Zlowout = 1'b1;
            dp.PCin    = 1'b1;
            dp.Read    = 1'b1;
            dp.MDRin   = 1'b1;
         end
         S_T2: begin
            dp.MDRout = 1'b1;
            dp.IRin   = 1'b1;
         end
         S_T3: begin
            unique case (cls)
               C_REG3: begin
                  dp.Rout = oh(rb);
                  dp.Yin  = 1'b1;
               end
               C_MULDIV: begin
                  dp.Rout = oh(ra);
                  dp.Yin  = 1'b1;
               end
               C_UNARY: begin
                  dp.Rout  = oh(rb);
                  dp.ZLOin = 1'b1;
               end
               C_MFHI: begin
                  dp.HIout     = 1'b1;
                  dp.enableReg = oh(ra);
               end
               C_MFLO: begin
                  dp.LOout     = 1'b1;
                  dp.enableReg = oh(ra);
               end
               C_ILL:   illegal = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            unique case (cls)
               C_REG3: begin
                  dp.Rout  = oh(rc);
                  dp.ZLOin = 1'b1;
               end
               C_MULDIV: begin
                  dp.Rout  = oh(rb);
                  dp.ZLOin = 1'b1;
                  dp.ZHIin = 1'b1;
               end
               C_UNARY: begin
                  dp.Zlowout   = 1'b1;
                  dp.enableReg = oh(ra);
               end
               default: ;
            endcase
         end
         S_T5: begin
            unique case (cls)
               C_REG3: begin
                  dp.Zlowout   = 1'b1;
                  dp.enableReg = oh(ra);
               end
               C_MULDIV: begin
                  dp.ZHighout = 1'b1;
                  dp.HIin     = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            dp.Zlowout = 1'b1;
            dp.LOin    = 1'b1;
         end
         default: ;
      endcase
   end

   // The ALU sees the opcode only while Z is being loaded.
   assign dp.operation = (dp.ZLOin || dp.ZHIin) ? opc : 5'd0;
   assign state        = state_q;
   assign halted       = (state_q == S_HALT);

endmodule
